// File: rtl/alu_muldiv_unit.sv
// Iterative multiply/divide sequencer for the EX stage: one bit per cycle into HI/LO,
// plus MFHI/MFLO/MTHI/MTLO service and pipeline stall generation.
`timescale 1ns/1ps
module alu_muldiv_unit #(
    parameter int NB_DATA  = 32,
    parameter int NB_FUNCT = 6,
    parameter int NB_COUNT = $clog2(NB_DATA) + 1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic [NB_FUNCT-1:0] i_funct,
    input  logic [NB_DATA-1:0]  i_rs_data,
    input  logic [NB_DATA-1:0]  i_rt_data,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_stall,
    output logic [NB_DATA-1:0]  o_mf_data,
    output logic [NB_DATA-1:0]  o_hi,
    output logic [NB_DATA-1:0]  o_lo
);

    localparam logic [NB_FUNCT-1:0] F_MULT  = NB_FUNCT'(6'b011000);
    localparam logic [NB_FUNCT-1:0] F_MULTU = NB_FUNCT'(6'b011001);
    localparam logic [NB_FUNCT-1:0] F_DIV   = NB_FUNCT'(6'b011010);
    localparam logic [NB_FUNCT-1:0] F_DIVU  = NB_FUNCT'(6'b011011);
    localparam logic [NB_FUNCT-1:0] F_MFHI  = NB_FUNCT'(6'b010000);
    localparam logic [NB_FUNCT-1:0] F_MTHI  = NB_FUNCT'(6'b010001);
    localparam logic [NB_FUNCT-1:0] F_MFLO  = NB_FUNCT'(6'b010010);
    localparam logic [NB_FUNCT-1:0] F_MTLO  = NB_FUNCT'(6'b010011);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t              state, next_state;
    logic [NB_COUNT-1:0] count;
    logic [NB_DATA-1:0]  hi, lo;
    logic [NB_DATA-1:0]  upper;    // product high half / partial remainder
    logic [NB_DATA-1:0]  lower;    // multiplier -> product low half / dividend -> quotient
    logic [NB_DATA-1:0]  operand;  // multiplicand or divisor magnitude
    logic                op_div, div_zero, neg_prod_quot, neg_rem;

    logic                is_muldiv, is_move, is_div, is_signed, accept, rt_zero;
    logic [NB_DATA-1:0]  mag_rs, mag_rt;
    logic [NB_DATA:0]    mul_sum, div_shift, div_trial;
    logic [2*NB_DATA-1:0] product, product_fix;
    logic [NB_DATA-1:0]  quot_fix, rem_fix;

    // NOTE: every signal driven from always_comb gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        is_muldiv = (i_funct == F_MULT) || (i_funct == F_MULTU) ||
                    (i_funct == F_DIV)  || (i_funct == F_DIVU);
        is_move   = (i_funct == F_MFHI) || (i_funct == F_MTHI) ||
                    (i_funct == F_MFLO) || (i_funct == F_MTLO);
        is_div    = i_funct[1];
        is_signed = ~i_funct[0];
        rt_zero   = (i_rt_data == '0);
        accept    = (state == S_IDLE) && i_valid && is_muldiv;
        o_stall   = i_valid && o_busy && (is_muldiv || is_move);

        o_mf_data = '0;
        if (i_funct == F_MFHI) o_mf_data = hi;
        if (i_funct == F_MFLO) o_mf_data = lo;

        mag_rs = (is_signed && i_rs_data[NB_DATA-1]) ? -i_rs_data : i_rs_data;
        mag_rt = (is_signed && i_rt_data[NB_DATA-1]) ? -i_rt_data : i_rt_data;

        mul_sum   = {1'b0, upper} + (lower[0] ? {1'b0, operand} : '0);
        div_shift = {upper, lower[NB_DATA-1]};
        div_trial = div_shift - {1'b0, operand};

        product     = {upper, lower};
        product_fix = neg_prod_quot ? -product : product;
        quot_fix    = neg_prod_quot ? -lower : lower;
        rem_fix     = neg_rem ? -upper : upper;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (accept) next_state = (is_div && rt_zero) ? S_FIX : S_RUN;
            S_RUN:  if (count == NB_COUNT'(1)) next_state = S_FIX;
            S_FIX:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            state  <= next_state;
            o_busy <= (next_state != S_IDLE);
            o_done <= (state == S_FIX);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            hi            <= '0;
            lo            <= '0;
            count         <= '0;
            upper         <= '0;
            lower         <= '0;
            operand       <= '0;
            op_div        <= 1'b0;
            div_zero      <= 1'b0;
            neg_prod_quot <= 1'b0;
            neg_rem       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_div        <= is_div;
                        div_zero      <= is_div && rt_zero;
                        neg_prod_quot <= is_signed && (i_rs_data[NB_DATA-1] ^ i_rt_data[NB_DATA-1]);
                        neg_rem       <= is_signed && i_rs_data[NB_DATA-1];
                        count         <= NB_COUNT'(NB_DATA);
                        if (is_div) begin
                            // Divide by zero keeps raw rs in upper for the HI write-back.
                            upper   <= rt_zero ? i_rs_data : '0;
                            lower   <= mag_rs;
                            operand <= mag_rt;
                        end else begin
                            upper   <= '0;
                            lower   <= mag_rt;
                            operand <= mag_rs;
                        end
                    end else if (i_valid && i_funct == F_MTHI) begin
                        hi <= i_rs_data;
                    end else if (i_valid && i_funct == F_MTLO) begin
                        lo <= i_rs_data;
                    end
                end
                S_RUN: begin
                    count <= count - NB_COUNT'(1);
                    if (op_div) begin
                        if (!div_trial[NB_DATA]) begin
                            upper <= div_trial[NB_DATA-1:0];
                            lower <= {lower[NB_DATA-2:0], 1'b1};
                        end else begin
                            upper <= div_shift[NB_DATA-1:0];
                            lower <= {lower[NB_DATA-2:0], 1'b0};
                        end
                    end else begin
                        upper <= mul_sum[NB_DATA:1];
                        lower <= {mul_sum[0], lower[NB_DATA-1:1]};
                    end
                end
                S_FIX: begin
                    if (div_zero) begin
                        hi <= upper;
                        lo <= '1;
                    end else if (op_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= product_fix[2*NB_DATA-1:NB_DATA];
                        lo <= product_fix[NB_DATA-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_hi = hi;
    assign o_lo = lo;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit: directed vector table, randomized ops against
// a plain-arithmetic reference model, and hand-written stall/back-to-back/reset sequences.
`timescale 1ns/1ps
module tb_alu_muldiv_unit;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic        i_clock = 1'b0;
    logic        i_reset, i_valid;
    logic [5:0]  i_funct;
    logic [31:0] i_rs_data, i_rt_data;
    logic        o_busy, o_done, o_stall;
    logic [31:0] o_mf_data, o_hi, o_lo;

    int total  = 0;
    int passed = 0;

    alu_muldiv_unit #(.NB_DATA(32), .NB_FUNCT(6)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_funct(i_funct),
        .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .o_busy(o_busy), .o_done(o_done),
        .o_stall(o_stall), .o_mf_data(o_mf_data), .o_hi(o_hi), .o_lo(o_lo)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        string       name;
        logic [5:0]  funct;
        logic [31:0] rs, rt, hi, lo;
        int          busy;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Architectural result {HI,LO} from plain integer arithmetic.
    function automatic logic [63:0] ref_muldiv(input logic [5:0] f, input logic [31:0] rs,
                                               input logic [31:0] rt);
        longint a, b, q, r;
        logic [63:0] p;
        a = longint'($signed(rs));
        b = longint'($signed(rt));
        p = '0;
        case (f)
            F_MULT:  p = 64'(a * b);
            F_MULTU: p = {32'b0, rs} * {32'b0, rt};
            F_DIV: begin
                if (rt == 0) p = {rs, 32'hFFFF_FFFF};
                else begin
                    q = a / b;
                    r = a % b;
                    p = {r[31:0], q[31:0]};
                end
            end
            F_DIVU: begin
                if (rt == 0) p = {rs, 32'hFFFF_FFFF};
                else p = {rs % rt, rs / rt};
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // Called at a negedge; presents the op for one edge and drops valid.
    task automatic issue(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
        i_valid   = 1'b1;
        i_funct   = f;
        i_rs_data = rs;
        i_rt_data = rt;
        @(negedge i_clock);
        i_valid = 1'b0;
        i_funct = 6'b000000;
    endtask

    // Counts busy cycles until the o_done cycle; returns at that cycle's negedge.
    task automatic wait_done(output int busy_cnt, output bit seen);
        busy_cnt = 0;
        seen     = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (o_done) begin
                seen = 1'b1;
                break;
            end
            if (o_busy) busy_cnt++;
            @(negedge i_clock);
        end
    endtask

    initial begin
        int          bcnt, bad;
        bit          seen;
        logic [5:0]  f;
        logic [31:0] rs, rt;

        vecs[0] = '{"mult_neg3x7",   F_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 33};
        vecs[1] = '{"multu_max",     F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        vecs[2] = '{"divu_100_7",    F_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33};
        vecs[3] = '{"div_neg7_2",    F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[4] = '{"div_min_neg1",  F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 33};
        vecs[5] = '{"divu_by_zero",  F_DIVU,  32'h0000_1234, 32'h0,         32'h0000_1234, 32'hFFFF_FFFF, 1};
        vecs[6] = '{"div_7_neg2",    F_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
        vecs[7] = '{"mult_min_min",  F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         33};
        vecs[8] = '{"div_by_zero_s", F_DIV,   32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1};
        vecs[9] = '{"divu_5_9",      F_DIVU,  32'd5,         32'd9,         32'd5,         32'd0,         33};

        i_reset = 1'b1; i_valid = 1'b0; i_funct = '0; i_rs_data = '0; i_rt_data = '0;
        repeat (2) @(negedge i_clock);
        i_reset = 1'b0;
        check("reset_busy", 64'(o_busy), 64'd0);
        check("reset_done", 64'(o_done), 64'd0);
        check("reset_hilo", {o_hi, o_lo}, 64'd0);

        // Directed vector table.
        foreach (vecs[i]) begin
            issue(vecs[i].funct, vecs[i].rs, vecs[i].rt);
            wait_done(bcnt, seen);
            check({vecs[i].name, "_done"}, 64'(seen), 64'd1);
            check({vecs[i].name, "_busy"}, 64'(bcnt), 64'(vecs[i].busy));
            check({vecs[i].name, "_hilo"}, {o_hi, o_lo}, {vecs[i].hi, vecs[i].lo});
            @(negedge i_clock);
            check({vecs[i].name, "_pulse"}, 64'(o_done), 64'd0);
        end

        // Randomized operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            f  = F_MULT | 6'($urandom_range(0, 3));
            rs = $urandom;
            if ($urandom_range(0, 7) == 0) rt = '0;
            else if ($urandom_range(0, 1) == 1) rt = $urandom;
            else rt = 32'($urandom_range(1, 300));
            issue(f, rs, rt);
            wait_done(bcnt, seen);
            check($sformatf("rand%0d_f%b_busy", i, f), 64'(bcnt),
                  64'((f[1] && rt == 0) ? 1 : 33));
            check($sformatf("rand%0d_f%b_%h_%h", i, f, rs, rt), {o_hi, o_lo}, ref_muldiv(f, rs, rt));
            @(negedge i_clock);
        end

        // Back-to-back issue in the o_done cycle.
        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(bcnt, seen);
        check("b2b_first_hilo", {o_hi, o_lo}, 64'hFFFF_FFFE_0000_0001);
        i_valid = 1'b1; i_funct = F_DIVU; i_rs_data = 32'd100; i_rt_data = 32'd7;
        #1;
        check("b2b_no_stall", 64'(o_stall), 64'd0);
        @(negedge i_clock);
        i_valid = 1'b0; i_funct = '0;
        wait_done(bcnt, seen);
        check("b2b_second_busy", 64'(bcnt), 64'd33);
        check("b2b_second_hilo", {o_hi, o_lo}, {32'd2, 32'd14});
        @(negedge i_clock);

        // MFLO held from cycle 5 of a MULT: stalls until the o_done cycle.
        issue(F_MULT, 32'd5, 32'hFFFF_FFFA);
        repeat (4) @(negedge i_clock);
        i_valid = 1'b1; i_funct = F_MFLO;
        bad = 0; seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            #1;
            if (o_done) begin
                seen = 1'b1;
                break;
            end
            if (!o_stall) bad++;
            @(negedge i_clock);
        end
        check("mflo_done_seen", 64'(seen), 64'd1);
        check("mflo_stall_while_busy", 64'(bad), 64'd0);
        check("mflo_done_stall", 64'(o_stall), 64'd0);
        check("mflo_done_data", 64'(o_mf_data), 64'hFFFF_FFE2);
        @(negedge i_clock);
        i_valid = 1'b0; i_funct = '0;

        // MTHI while busy is stalled and discarded; unrecognised funct never stalls.
        issue(F_MULT, 32'd2, 32'd3);
        i_valid = 1'b1; i_funct = F_MTHI; i_rs_data = 32'hAA;
        #1;
        check("mthi_busy_stall", 64'(o_stall), 64'd1);
        i_funct = F_ADD;
        #1;
        check("unknown_busy_stall", 64'(o_stall), 64'd0);
        check("unknown_mf_data", 64'(o_mf_data), 64'd0);
        i_funct = F_MTHI;
        repeat (3) @(negedge i_clock);
        i_valid = 1'b0; i_funct = '0;
        check("mthi_busy_hi_kept", 64'(o_hi), 64'hFFFF_FFFF);
        wait_done(bcnt, seen);
        check("mult_2x3_hilo", {o_hi, o_lo}, 64'd6);
        @(negedge i_clock);
        i_valid = 1'b1; i_funct = F_MTHI; i_rs_data = 32'hAA;
        @(negedge i_clock);
        check("mthi_idle_hi", 64'(o_hi), 64'hAA);
        i_funct = F_MTLO; i_rs_data = 32'h55;
        @(negedge i_clock);
        check("mtlo_idle_lo", 64'(o_lo), 64'h55);
        i_funct = F_MFHI;
        #1;
        check("mfhi_idle_data", 64'(o_mf_data), 64'hAA);
        check("mfhi_idle_stall", 64'(o_stall), 64'd0);
        @(negedge i_clock);
        i_valid = 1'b0; i_funct = '0;

        // Reset in RUN cycle 10 abandons the operation.
        issue(F_MULT, 32'h1234, 32'h10);
        repeat (9) @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
        check("abort_busy", 64'(o_busy), 64'd0);
        check("abort_done", 64'(o_done), 64'd0);
        check("abort_hilo", {o_hi, o_lo}, 64'd0);
        bad = 0;
        for (int n = 0; n < 40; n++) begin
            if (o_done || o_busy) bad++;
            @(negedge i_clock);
        end
        check("abort_no_done_pulse", 64'(bad), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
